// File: rtl/jam_job_arbiter.sv
// jam_job_arbiter: shares one 8x8 job-assignment engine among NREQ requesters.
// Round-robin grant, one-cycle engine reset, cost-ROM routing to the granted
// requester, result capture on engine Valid, and a watchdog for hung runs.
module jam_job_arbiter #(
   parameter int NREQ    = 2,
   parameter int TO_W    = 20,
   parameter int TIMEOUT = 1048575
) (
   input  logic                CLK,
   input  logic                RST,
   input  logic [NREQ-1:0]     req,
   output logic [NREQ-1:0]     gnt,
   output logic [NREQ-1:0]     done,
   output logic                err,
   output logic [9:0]          res_min,
   output logic [3:0]          res_cnt,
   output logic                busy,
   output logic [2:0]          rom_w,
   output logic [2:0]          rom_j,
   input  logic [7*NREQ-1:0]   rom_cost,
   output logic                eng_rst,
   input  logic [2:0]          eng_w,
   input  logic [2:0]          eng_j,
   output logic [6:0]          eng_cost,
   input  logic                eng_valid,
   input  logic [9:0]          eng_min,
   input  logic [3:0]          eng_cnt
);

   localparam int unsigned      NR      = NREQ;
   localparam int               IW      = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam logic [NREQ-1:0]  ONE_HOT = NREQ'(1);
   localparam logic [TO_W-1:0]  WD_LAST = TO_W'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ENG_RST,
      S_RUN,
      S_RESP
   } state_t;

   state_t            r_state;
   logic [IW-1:0]     r_last;
   logic [IW-1:0]     r_gidx;
   logic [NREQ-1:0]   r_gnt;
   logic [NREQ-1:0]   r_done;
   logic              r_err;
   logic [9:0]        r_min;
   logic [3:0]        r_cnt;
   logic [TO_W-1:0]   r_wd;

   logic              w_any;
   logic [IW-1:0]     w_pick;
   logic [6:0]        w_cost;

   // Next winner: first requesting index after the last grant, wrapping at NREQ.
   always_comb begin : pick_next
      int unsigned cand;
      cand   = 0;
      w_any  = 1'b0;
      w_pick = '0;
      for (int unsigned k = 1; k <= NR; k++) begin
         cand = 32'(r_last) + k;
         if (cand >= NR) cand = cand - NR;
         if (!w_any && req[cand[IW-1:0]]) begin
            w_any  = 1'b1;
            w_pick = cand[IW-1:0];
         end
      end
   end

   // Route the granted requester's ROM data to the engine; nothing while idle.
   always_comb begin
      w_cost = '0;
      if (r_state != S_IDLE) begin
         for (int unsigned k = 0; k < NR; k++) begin
            if (32'(r_gidx) == k) w_cost = rom_cost[7*k +: 7];
         end
      end
   end

   // Arbitration FSM with registered grant, done pulse, results and watchdog.
   always_ff @(posedge CLK) begin
      if (RST) begin
         r_state <= S_IDLE;
         r_last  <= IW'(NREQ - 1);
         r_gidx  <= '0;
         r_gnt   <= '0;
         r_done  <= '0;
         r_err   <= 1'b0;
         r_min   <= 10'd1023;
         r_cnt   <= '0;
         r_wd    <= '0;
      end else begin
         r_done <= '0;
         case (r_state)
            S_IDLE: begin
               if (w_any) begin
                  r_gnt   <= ONE_HOT << w_pick;
                  r_gidx  <= w_pick;
                  r_last  <= w_pick;
                  r_state <= S_ENG_RST;
               end
            end
            S_ENG_RST: begin
               r_wd    <= '0;
               r_state <= S_RUN;
            end
            S_RUN: begin
               r_wd <= r_wd + TO_W'(1);
               // Priority: requester withdrawal, then engine Valid, then watchdog.
               if (!req[r_gidx]) begin
                  r_gnt   <= '0;
                  r_state <= S_IDLE;
               end else if (eng_valid) begin
                  r_min   <= eng_min;
                  r_cnt   <= eng_cnt;
                  r_err   <= 1'b0;
                  r_done  <= r_gnt;
                  r_state <= S_RESP;
               end else if (r_wd == WD_LAST) begin
                  r_min   <= 10'd1023;
                  r_cnt   <= '0;
                  r_err   <= 1'b1;
                  r_done  <= r_gnt;
                  r_state <= S_RESP;
               end
            end
            S_RESP: begin
               r_gnt   <= '0;
               r_state <= S_IDLE;
            end
            default: begin
               r_gnt   <= '0;
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign gnt      = r_gnt;
   assign done     = r_done;
   assign err      = r_err;
   assign res_min  = r_min;
   assign res_cnt  = r_cnt;
   assign busy     = (r_state != S_IDLE);
   assign eng_rst  = RST | (r_state == S_ENG_RST);
   assign rom_w    = eng_w;
   assign rom_j    = eng_j;
   assign eng_cost = w_cost;

endmodule
